// File: rtl/wish_pkg.sv
// Shared definitions for the wish_pack / wish_unpack width converters.
//   WISH_LITTLE / WISH_BIG : values for the LITTLE_ENDIAN parameter.
//   wish_state_e           : holding-register state (EMPTY / SEND).
//   lane_idx()             : maps a beat counter to the wide-word lane it carries,
//                            shared so packer and unpacker agree on lane order.
package wish_pkg;

    localparam bit WISH_LITTLE = 1'b1;
    localparam bit WISH_BIG    = 1'b0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } wish_state_e;

    function automatic int unsigned lane_idx(input int unsigned cnt,
                                             input int unsigned num_pack,
                                             input bit          little_endian);
        return little_endian ? cnt : (num_pack - 1 - cnt);
    endfunction

endpackage

// File: rtl/wish_unpack_if.sv
// Bus bundle for wish_unpack: wide Wishbone-style source side (s_*) and
// narrow beat sink side (d_*).
//   slave  : the unpacker's view (consumes wide words, produces beats)
//   master : the environment's view (offers wide words, accepts beats)
interface wish_unpack_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4,
    parameter int TGC_WIDTH  = 2
);

    logic                           s_stb_i;
    logic                           s_cyc_i;
    logic                           s_ack_o;
    logic                           s_stall_o;
    logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i;
    logic [TGC_WIDTH-1:0]           s_tgc_i;

    logic                           d_stb_o;
    logic                           d_cyc_o;
    logic                           d_ack_i;
    logic [DATA_WIDTH-1:0]          d_dat_o;
    logic [TGC_WIDTH-1:0]           d_tgc_o;
    logic                           d_last_o;

    modport slave (
        input  s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, d_ack_i,
        output s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o, d_last_o
    );

    modport master (
        output s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, d_ack_i,
        input  s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o, d_last_o
    );

endinterface

// File: rtl/wish_lane_sel.sv
// Purely combinational NUM_PACK:1 lane multiplexer.
//   word_i : NUM_PACK lanes of DATA_WIDTH bits, lane 0 in the low bits
//   sel_i  : lane index; out-of-range values select zero
//   lane_o : selected lane
module wish_lane_sel #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4
) (
    input  logic [DATA_WIDTH*NUM_PACK-1:0] word_i,
    input  logic [$clog2(NUM_PACK)-1:0]    sel_i,
    output logic [DATA_WIDTH-1:0]          lane_o
);

    localparam int SEL_W = $clog2(NUM_PACK);

    always_comb begin
        lane_o = '0;
        for (int unsigned i = 0; i < NUM_PACK; i++) begin
            if (sel_i == SEL_W'(i)) begin
                lane_o = word_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/wish_unpack.sv
// Width-down converter: accepts one wide word of NUM_PACK lanes and emits it
// as NUM_PACK narrow beats, lane order chosen by LITTLE_ENDIAN.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : wish_unpack_if.slave
//            s_stb_i/s_cyc_i/s_dat_i/s_tgc_i in, s_ack_o/s_stall_o out (wide side)
//            d_stb_o/d_cyc_o/d_dat_o/d_tgc_o/d_last_o out, d_ack_i in (narrow side)
// A single holding register is refilled either when empty or on the final
// beat of the current word, which gives bubble-free back-to-back words.
module wish_unpack
    import wish_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter bit LITTLE_ENDIAN = WISH_LITTLE
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    wish_unpack_if.slave  bus
);

    localparam int                CNT_W    = $clog2(NUM_PACK);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_PACK - 1);

    wish_state_e                    state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [DATA_WIDTH*NUM_PACK-1:0] hold_q, hold_d;
    logic [TGC_WIDTH-1:0]           tgc_q, tgc_d;

    logic                           valid;
    logic                           last;
    logic                           beat_done;
    logic                           stall;
    logic                           accept;
    logic [CNT_W-1:0]               lane;
    logic [DATA_WIDTH-1:0]          lane_dat;

    assign valid     = (state_q == ST_SEND);
    assign last      = (cnt_q == CNT_LAST);
    assign beat_done = valid & bus.d_ack_i;

    // Stall is forced high during reset so no word can be acked then.
    assign stall  = rst_ni ? (valid & ~(beat_done & last)) : 1'b1;
    assign accept = bus.s_stb_i & bus.s_cyc_i & ~stall;

    assign lane = CNT_W'(lane_idx(32'(cnt_q), NUM_PACK, LITTLE_ENDIAN));

    wish_lane_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PACK   (NUM_PACK)
    ) u_lane_sel (
        .word_i (hold_q),
        .sel_i  (lane),
        .lane_o (lane_dat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        tgc_d   = tgc_q;
        // accept is only possible when empty or on the final-beat handoff,
        // so it takes priority over the beat-advance branch.
        if (accept) begin
            state_d = ST_SEND;
            cnt_d   = '0;
            hold_d  = bus.s_dat_i;
            tgc_d   = bus.s_tgc_i;
        end else if (beat_done) begin
            if (last) begin
                state_d = ST_EMPTY;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            hold_q  <= '0;
            tgc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            tgc_q   <= tgc_d;
        end
    end

    assign bus.s_ack_o   = accept;
    assign bus.s_stall_o = stall;
    assign bus.d_stb_o   = valid;
    assign bus.d_cyc_o   = valid;
    assign bus.d_last_o  = valid & last;
    assign bus.d_dat_o   = valid ? lane_dat : '0;
    assign bus.d_tgc_o   = valid ? tgc_q : '0;

endmodule

// File: tb/tb_wish_unpack.sv
// Scoreboard bench for wish_unpack: a little-endian and a big-endian instance
// share one stimulus stream; each has its own expected-beat queue.
module tb_wish_unpack;
    import wish_pkg::*;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int TW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          stb = 1'b0;
    logic          cyc = 1'b0;
    logic          ack = 1'b0;
    logic [31:0]   dat = '0;
    logic [1:0]    tgc = '0;

    wish_unpack_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) ifl ();
    wish_unpack_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) ifb ();

    assign ifl.s_stb_i = stb;
    assign ifl.s_cyc_i = cyc;
    assign ifl.s_dat_i = dat;
    assign ifl.s_tgc_i = tgc;
    assign ifl.d_ack_i = ack;
    assign ifb.s_stb_i = stb;
    assign ifb.s_cyc_i = cyc;
    assign ifb.s_dat_i = dat;
    assign ifb.s_tgc_i = tgc;
    assign ifb.d_ack_i = ack;

    wish_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(WISH_LITTLE))
        u_le (.clk_i(clk), .rst_ni(rst_n), .bus(ifl));
    wish_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(WISH_BIG))
        u_be (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int first_ack, first_beat, last_beat;
    int ack_mode = 0;
    int ack_ph = 0;
    bit cyc_glitch = 1'b0;

    logic [33:0] src_q[$];      // {tag, word} still to be offered
    logic [10:0] exp_q[2][$];   // {data, tag, last} per instance

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic mon(input int k, input logic d_stb, input logic d_cyc, input logic d_last,
                       input logic s_ack, input logic s_stall, input logic [7:0] d_dat,
                       input logic [1:0] d_tgc, output bit acc);
        bit          v, l, st;
        logic [10:0] f;
        int          ln;
        string       p;
        p  = (k == 0) ? "le" : "be";
        v  = (exp_q[k].size() != 0);
        l  = (exp_q[k].size() == 1);
        st = v && !(ack && l);
        acc = stb && cyc && !st;
        chk({p, ".stb"},   d_stb, v);
        chk({p, ".cyc"},   d_cyc, v);
        chk({p, ".stall"}, s_stall, st);
        chk({p, ".ack"},   s_ack, acc);
        chk({p, ".excl"},  s_ack & s_stall, 0);
        if (v) begin
            f = exp_q[k][0];
            chk({p, ".dat"},  d_dat, f[10:3]);
            chk({p, ".tgc"},  d_tgc, f[2:1]);
            chk({p, ".last"}, d_last, f[0]);
            if (ack) begin
                void'(exp_q[k].pop_front());
                if (k == 0) begin
                    if (first_beat < 0) first_beat = cyc_n;
                    last_beat = cyc_n;
                end
            end
        end else begin
            chk({p, ".dat0"},  d_dat, 0);
            chk({p, ".tgc0"},  d_tgc, 0);
            chk({p, ".last0"}, d_last, 0);
        end
        if (acc) begin
            if (k == 0 && first_ack < 0) first_ack = cyc_n;
            for (int i = 0; i < NP; i++) begin
                ln = (k == 0) ? i : (NP - 1 - i);
                exp_q[k].push_back({dat[ln*DW +: DW], tgc, (i == NP - 1)});
            end
        end
    endtask

    // Source and sink driver, just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (ack_mode)
            0: ack = 1'b1;
            1: begin
                ack    = (ack_ph == 0);
                ack_ph = (ack_ph + 1) % 3;
            end
            default: ack = 1'($urandom_range(0, 1));
        endcase
        if (src_q.size() > 0) begin
            stb        = 1'b1;
            cyc        = !(cyc_glitch && ($urandom_range(0, 3) == 0));
            {tgc, dat} = src_q[0];
        end else begin
            stb = 1'b0;
            cyc = 1'b0;
        end
    end

    // Monitor on the falling edge.
    initial forever begin
        bit a0, a1;
        @(negedge clk);
        if (rst_n) begin
            cyc_n++;
            mon(0, ifl.d_stb_o, ifl.d_cyc_o, ifl.d_last_o, ifl.s_ack_o, ifl.s_stall_o,
                ifl.d_dat_o, ifl.d_tgc_o, a0);
            mon(1, ifb.d_stb_o, ifb.d_cyc_o, ifb.d_last_o, ifb.s_ack_o, ifb.s_stall_o,
                ifb.d_dat_o, ifb.d_tgc_o, a1);
            if (a0) void'(src_q.pop_front());
        end
    end

    task automatic start_phase();
        first_ack  = -1;
        first_beat = -1;
        last_beat  = -1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (src_q.size() == 0 && exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
        end
        chk({tag, ".drain"}, src_q.size() + exp_q[0].size() + exp_q[1].size(), 0);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, ".le.stb"},   ifl.d_stb_o, 0);
        chk({tag, ".le.cyc"},   ifl.d_cyc_o, 0);
        chk({tag, ".le.last"},  ifl.d_last_o, 0);
        chk({tag, ".le.ack"},   ifl.s_ack_o, 0);
        chk({tag, ".le.stall"}, ifl.s_stall_o, 1);
        chk({tag, ".le.dat"},   ifl.d_dat_o, 0);
        chk({tag, ".le.tgc"},   ifl.d_tgc_o, 0);
        chk({tag, ".be.stb"},   ifb.d_stb_o, 0);
        chk({tag, ".be.ack"},   ifb.s_ack_o, 0);
        chk({tag, ".be.stall"}, ifb.s_stall_o, 1);
    endtask

    initial begin
        logic [31:0] w;
        logic [1:0]  t;

        #1;
        reset_outputs("por");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single word, lane order on both instances, 1-cycle latency.
        start_phase();
        src_q.push_back({2'b10, 32'hDDCCBBAA});
        drain("order");
        chk("order.latency", first_beat - first_ack, 1);
        chk("order.span",    last_beat - first_ack, 4);

        // Back-to-back words with no bubble.
        start_phase();
        src_q.push_back({2'b01, 32'h44332211});
        src_q.push_back({2'b11, 32'h88776655});
        drain("b2b");
        chk("b2b.span", last_beat - first_ack, 8);

        // Backpressure 1,0,0 pattern.
        ack_mode = 1;
        ack_ph   = 0;
        src_q.push_back({2'b01, 32'hDDCCBBAA});
        drain("bp");
        ack_mode = 0;

        // Asynchronous reset after beat BB, next word offered during reset.
        src_q.push_back({2'b10, 32'hDDCCBBAA});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (exp_q[0].size() == 2) break;
        end
        chk("rst.wait", exp_q[0].size(), 2);
        src_q.push_back({2'b01, 32'h0D0C0B0A});
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        reset_outputs("midrst");
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        start_phase();
        drain("rst");
        chk("rst.latency", first_beat - first_ack, 1);

        // Random words, random sink stalls, occasional strobes without cyc.
        ack_mode   = 2;
        cyc_glitch = 1'b1;
        for (int i = 0; i < 24; i++) begin
            w = $urandom();
            t = 2'($urandom_range(0, 3));
            src_q.push_back({t, w});
        end
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
